id_ex_stage: RTL

ID/EX pipeline register with integrated EX-stage operand forwarding. It captures decoded operands and control from the decode stage, then drives the ALU's two 32-bit sources and 4-bit op code. It also passes memory and writeback control down to the EX/MEM register. It supports stall (hold), flush (bubble) and load-use hazard detection.

---
 rtl/id_ex_stage_pkg.sv | 28 ++
 rtl/ex_forward_unit.sv | 39 +++
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU op codes,
// forwarding-select encoding and the registered control bundle.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_LW  = 4'b0101;
    localparam logic [3:0] ALU_SW  = 4'b0110;
    localparam logic [3:0] ALU_BEQ = 4'b0111;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ex_ctrl_t;

endpackage

// File: rtl/ex_forward_unit.sv
// Per-operand forwarding mux: picks EX/MEM, then MEM/WB, then the registered
// value. Register 0 never matches, so it always reads the registered data.
module ex_forward_unit
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_reg,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_reg_write,
    input  logic [AW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [AW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output fwd_sel_t      fwd_sel,
    output logic [DW-1:0] fwd_data
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_reg);
    assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_reg);

    always_comb begin
        fwd_sel  = FWD_REG;
        fwd_data = reg_data;
        if (exmem_hit) begin
            fwd_sel  = FWD_EXMEM;
            fwd_data = exmem_result;
        end else if (memwb_hit) begin
            fwd_sel  = FWD_MEMWB;
            fwd_data = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, stall/flush
// control and load-use hazard detection against the decode slot.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          id_valid_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    input  logic [DW-1:0] id_imm_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    input  logic [AW-1:0] id_rd_i,
    input  logic [3:0]    id_alu_ctrl_i,
    input  logic          id_alu_src_i,
    input  logic          id_reg_write_i,
    input  logic          id_mem_read_i,
    input  logic          id_mem_write_i,
    input  logic          id_mem_to_reg_i,
    input  logic          id_branch_i,
    input  logic          exmem_reg_write_i,
    input  logic [AW-1:0] exmem_rd_i,
    input  logic [DW-1:0] exmem_result_i,
    input  logic          memwb_reg_write_i,
    input  logic [AW-1:0] memwb_rd_i,
    input  logic [DW-1:0] memwb_data_i,
    output logic [DW-1:0] alu_src1_o,
    output logic [DW-1:0] alu_src2_o,
    output logic [3:0]    alu_ctrl_o,
    output logic [DW-1:0] store_data_o,
    output logic [AW-1:0] rd_o,
    output logic          reg_write_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic          mem_to_reg_o,
    output logic          branch_o,
    output logic          valid_o,
    output logic          load_use_o
);

    logic [DW-1:0] rs_data_p1;
    logic [DW-1:0] rt_data_p1;
    logic [DW-1:0] imm_p1;
    logic [AW-1:0] rs_p1;
    logic [AW-1:0] rt_p1;
    logic [AW-1:0] rd_p1;
    logic [3:0]    alu_ctrl_p1;
    logic          alu_src_p1;
    ex_ctrl_t      ctrl_p1;
    logic          vld_p1;

    fwd_sel_t      rs_sel;
    fwd_sel_t      rt_sel;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    // ID -> EX boundary
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rs_data_p1  <= '0;
            rt_data_p1  <= '0;
            imm_p1      <= '0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
            alu_ctrl_p1 <= '0;
            alu_src_p1  <= 1'b0;
            ctrl_p1     <= '0;
            vld_p1      <= 1'b0;
        end else if (flush_i) begin
            rs_data_p1  <= '0;
            rt_data_p1  <= '0;
            imm_p1      <= '0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
            alu_ctrl_p1 <= '0;
            alu_src_p1  <= 1'b0;
            ctrl_p1     <= '0;
            vld_p1      <= 1'b0;
        end else if (stall_i) begin
            // Capture forwarded operands so they outlive a producer retiring mid-stall
            if (rs_sel != FWD_REG) rs_data_p1 <= rs_fwd;
            if (rt_sel != FWD_REG) rt_data_p1 <= rt_fwd;
        end else begin
            rs_data_p1         <= id_rs_data_i;
            rt_data_p1         <= id_rt_data_i;
            imm_p1             <= id_imm_i;
            rs_p1              <= id_rs_i;
            rt_p1              <= id_rt_i;
            rd_p1              <= id_rd_i;
            alu_ctrl_p1        <= id_alu_ctrl_i;
            alu_src_p1         <= id_alu_src_i;
            ctrl_p1.reg_write  <= id_reg_write_i & id_valid_i;
            ctrl_p1.mem_read   <= id_mem_read_i & id_valid_i;
            ctrl_p1.mem_write  <= id_mem_write_i & id_valid_i;
            ctrl_p1.mem_to_reg <= id_mem_to_reg_i;
            ctrl_p1.branch     <= id_branch_i & id_valid_i;
            vld_p1             <= id_valid_i;
        end
    end

    ex_forward_unit #(.DW(DW), .AW(AW)) u_fwd_rs (
        .src_reg         (rs_p1),
        .reg_data        (rs_data_p1),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_rd        (exmem_rd_i),
        .exmem_result    (exmem_result_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_rd        (memwb_rd_i),
        .memwb_data      (memwb_data_i),
        .fwd_sel         (rs_sel),
        .fwd_data        (rs_fwd)
    );

    ex_forward_unit #(.DW(DW), .AW(AW)) u_fwd_rt (
        .src_reg         (rt_p1),
        .reg_data        (rt_data_p1),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_rd        (exmem_rd_i),
        .exmem_result    (exmem_result_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_rd        (memwb_rd_i),
        .memwb_data      (memwb_data_i),
        .fwd_sel         (rt_sel),
        .fwd_data        (rt_fwd)
    );

    // EX stage outputs
    assign alu_src1_o   = rs_fwd;
    assign alu_src2_o   = alu_src_p1 ? imm_p1 : rt_fwd;
    assign store_data_o = rt_fwd;
    assign alu_ctrl_o   = alu_ctrl_p1;
    assign rd_o         = rd_p1;
    assign reg_write_o  = ctrl_p1.reg_write;
    assign mem_read_o   = ctrl_p1.mem_read;
    assign mem_write_o  = ctrl_p1.mem_write;
    assign mem_to_reg_o = ctrl_p1.mem_to_reg;
    assign branch_o     = ctrl_p1.branch;
    assign valid_o      = vld_p1;

    assign load_use_o = vld_p1 & ctrl_p1.mem_read & (rd_p1 != '0) & id_valid_i &
                        ((rd_p1 == id_rs_i) | (rd_p1 == id_rt_i));

endmodule
